// File: rtl/ptpv2_rtc_pkg.sv
// Shared PTPv2 RTC definitions: update-op encoding, scheduler states and the ns modulus.
package ptpv2_rtc_pkg;

    localparam logic [1:0] RTC_OP_OFST = 2'b00;
    localparam logic [1:0] RTC_OP_CLR  = 2'b01;
    localparam logic [1:0] RTC_OP_TICK = 2'b10;
    localparam logic [1:0] RTC_OP_NOP  = 2'b11;

    localparam int unsigned RTC_NS_MAX = 32'd1_000_000_000;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWaitWin,
        StApply,
        StSettle,
        StAck
    } rtc_adj_state_e;

endpackage

// File: rtl/rtc_guard_win.sv
// Rollover guard-window comparator; flags ns values too close to the second carry.
module rtc_guard_win #(
    parameter int unsigned NS_MAX   = 32'd1_000_000_000,
    parameter int unsigned GUARD_NS = 32'd1_000_000
) (
    input  logic [31:0] ns_i,
    output logic        in_guard_o
);

    // Out-of-range ns (>= NS_MAX) lands in the upper half of the window.
    assign in_guard_o = (ns_i >= 32'(NS_MAX - GUARD_NS)) || (ns_i < 32'(GUARD_NS));

endmodule

// File: rtl/rtc_adj_sched.sv
// Arbitrates host and servo RTC updates onto the single rtc_unit load port,
// holding offset loads off until the ns counter is clear of the rollover.
module rtc_adj_sched
    import ptpv2_rtc_pkg::*;
#(
    parameter int unsigned NS_MAX       = RTC_NS_MAX,
    parameter int unsigned GUARD_NS     = 32'd1_000_000,
    parameter int unsigned SETTLE_CYC   = 4,
    parameter logic [31:0] TICK_INC_RST = 32'h1999_999a
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rtc_ns_i,
    input  logic        host_req_i,
    input  logic [1:0]  host_op_i,
    input  logic [47:0] host_sc_i,
    input  logic [31:0] host_ns_i,
    input  logic [31:0] host_tick_i,
    output logic        host_ack_o,
    input  logic        srv_req_i,
    input  logic [1:0]  srv_op_i,
    input  logic [47:0] srv_sc_i,
    input  logic [31:0] srv_ns_i,
    input  logic [31:0] srv_tick_i,
    output logic        srv_ack_o,
    output logic        ofst_ld_o,
    output logic        clr_o,
    output logic        tick_ld_o,
    output logic [47:0] sc_ofst_o,
    output logic [31:0] ns_ofst_o,
    output logic [31:0] tick_inc_o,
    output logic        busy_o,
    output logic [15:0] defer_cnt_o
);

    rtc_adj_state_e state_q, state_d;
    logic        gnt_srv_q, gnt_srv_d;
    logic        last_srv_q, last_srv_d;
    logic [1:0]  op_q, op_d;
    logic [47:0] sc_q, sc_d;
    logic [31:0] ns_q, ns_d;
    logic [31:0] tick_q, tick_d;
    logic [7:0]  settle_q, settle_d;
    logic [15:0] defer_q, defer_d;
    logic [47:0] sc_ofst_q, sc_ofst_d;
    logic [31:0] ns_ofst_q, ns_ofst_d;
    logic [31:0] tick_inc_q, tick_inc_d;
    logic        ofst_ld_q, ofst_ld_d;
    logic        clr_q, clr_d;
    logic        tick_ld_q, tick_ld_d;
    logic        host_ack_q, host_ack_d;
    logic        srv_ack_q, srv_ack_d;
    logic        in_guard;
    logic        pick_srv;

    rtc_guard_win #(
        .NS_MAX  (NS_MAX),
        .GUARD_NS(GUARD_NS)
    ) u_guard (
        .ns_i      (rtc_ns_i),
        .in_guard_o(in_guard)
    );

    // Host clear pre-empts the round-robin; otherwise the last-granted side loses a tie.
    assign pick_srv = srv_req_i &&
                      (!host_req_i || ((host_op_i != RTC_OP_CLR) && !last_srv_q));

    always_comb begin
        state_d    = state_q;
        gnt_srv_d  = gnt_srv_q;
        last_srv_d = last_srv_q;
        op_d       = op_q;
        sc_d       = sc_q;
        ns_d       = ns_q;
        tick_d     = tick_q;
        settle_d   = settle_q;
        defer_d    = defer_q;
        sc_ofst_d  = sc_ofst_q;
        ns_ofst_d  = ns_ofst_q;
        tick_inc_d = tick_inc_q;
        ofst_ld_d  = 1'b0;
        clr_d      = 1'b0;
        tick_ld_d  = 1'b0;
        host_ack_d = 1'b0;
        srv_ack_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (host_req_i || srv_req_i) begin
                    gnt_srv_d  = pick_srv;
                    last_srv_d = pick_srv;
                    op_d       = pick_srv ? srv_op_i   : host_op_i;
                    sc_d       = pick_srv ? srv_sc_i   : host_sc_i;
                    ns_d       = pick_srv ? srv_ns_i   : host_ns_i;
                    tick_d     = pick_srv ? srv_tick_i : host_tick_i;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                unique case (op_q)
                    RTC_OP_OFST: state_d = in_guard ? StWaitWin : StApply;
                    RTC_OP_CLR,
                    RTC_OP_TICK: state_d = StApply;
                    RTC_OP_NOP: begin
                        state_d    = StAck;
                        host_ack_d = !gnt_srv_q;
                        srv_ack_d  = gnt_srv_q;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StWaitWin: begin
                if (defer_q != 16'hFFFF) begin
                    defer_d = defer_q + 16'd1;
                end
                if (!in_guard) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                case (op_q)
                    RTC_OP_OFST: begin
                        sc_ofst_d = sc_q;
                        ns_ofst_d = ns_q;
                        ofst_ld_d = 1'b1;
                    end
                    RTC_OP_CLR:  clr_d = 1'b1;
                    RTC_OP_TICK: begin
                        tick_inc_d = tick_q;
                        tick_ld_d  = 1'b1;
                    end
                    default: ;
                endcase
                settle_d = 8'(SETTLE_CYC - 1);
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == 8'd0) begin
                    state_d    = StAck;
                    host_ack_d = !gnt_srv_q;
                    srv_ack_d  = gnt_srv_q;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_srv_q  <= 1'b0;
            last_srv_q <= 1'b1;
            op_q       <= RTC_OP_NOP;
            sc_q       <= '0;
            ns_q       <= '0;
            tick_q     <= '0;
            settle_q   <= '0;
            defer_q    <= '0;
            sc_ofst_q  <= '0;
            ns_ofst_q  <= '0;
            tick_inc_q <= TICK_INC_RST;
            ofst_ld_q  <= 1'b0;
            clr_q      <= 1'b0;
            tick_ld_q  <= 1'b0;
            host_ack_q <= 1'b0;
            srv_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_srv_q  <= gnt_srv_d;
            last_srv_q <= last_srv_d;
            op_q       <= op_d;
            sc_q       <= sc_d;
            ns_q       <= ns_d;
            tick_q     <= tick_d;
            settle_q   <= settle_d;
            defer_q    <= defer_d;
            sc_ofst_q  <= sc_ofst_d;
            ns_ofst_q  <= ns_ofst_d;
            tick_inc_q <= tick_inc_d;
            ofst_ld_q  <= ofst_ld_d;
            clr_q      <= clr_d;
            tick_ld_q  <= tick_ld_d;
            host_ack_q <= host_ack_d;
            srv_ack_q  <= srv_ack_d;
        end
    end

    assign host_ack_o  = host_ack_q;
    assign srv_ack_o   = srv_ack_q;
    assign ofst_ld_o   = ofst_ld_q;
    assign clr_o       = clr_q;
    assign tick_ld_o   = tick_ld_q;
    assign sc_ofst_o   = sc_ofst_q;
    assign ns_ofst_o   = ns_ofst_q;
    assign tick_inc_o  = tick_inc_q;
    assign busy_o      = (state_q != StIdle);
    assign defer_cnt_o = defer_q;

endmodule

// File: tb/tb_rtc_adj_sched.sv
// Directed bench for rtc_adj_sched: arbitration, guard deferral, strobe/ack timing and reset.
module tb_rtc_adj_sched;

    localparam longint NS_MOD = 64'd1_000_000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rtc_ns;
    logic        host_req, srv_req;
    logic [1:0]  host_op, srv_op;
    logic [47:0] host_sc, srv_sc;
    logic [31:0] host_ns, srv_ns, host_tick, srv_tick;
    logic        host_ack, srv_ack;
    logic        ofst_ld, clr, tick_ld, busy;
    logic [47:0] sc_ofst;
    logic [31:0] ns_ofst, tick_inc;
    logic [15:0] defer_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int excl_viol = 0;
    int ns_step = 0;

    int strb_k, ack_k, n_strb;
    logic [2:0] strb_kind;
    logic hack, sack;
    int acks_seen;

    always #5 clk = ~clk;

    rtc_adj_sched dut (
        .clk        (clk),
        .rst        (rst),
        .rtc_ns_i   (rtc_ns),
        .host_req_i (host_req),
        .host_op_i  (host_op),
        .host_sc_i  (host_sc),
        .host_ns_i  (host_ns),
        .host_tick_i(host_tick),
        .host_ack_o (host_ack),
        .srv_req_i  (srv_req),
        .srv_op_i   (srv_op),
        .srv_sc_i   (srv_sc),
        .srv_ns_i   (srv_ns),
        .srv_tick_i (srv_tick),
        .srv_ack_o  (srv_ack),
        .ofst_ld_o  (ofst_ld),
        .clr_o      (clr),
        .tick_ld_o  (tick_ld),
        .sc_ofst_o  (sc_ofst),
        .ns_ofst_o  (ns_ofst),
        .tick_inc_o (tick_inc),
        .busy_o     (busy),
        .defer_cnt_o(defer_cnt)
    );

    always @(negedge clk) begin
        if ($countones({ofst_ld, clr, tick_ld}) > 1) excl_viol++;
        if (host_ack && srv_ack) excl_viol++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // k counts edges from the next posedge (k=0 is the grant edge when idle).
    task automatic wait_ack(input int budget, output int s_k, output int a_k, output int ns_cnt,
                            output logic [2:0] kind, output logic h, output logic s);
        s_k = -1; a_k = -1; ns_cnt = 0; kind = 3'b000; h = 1'b0; s = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (ns_step != 0) rtc_ns = 32'((longint'(rtc_ns) + longint'(ns_step)) % NS_MOD);
            if (ofst_ld || clr || tick_ld) begin
                ns_cnt++;
                if (s_k < 0) begin
                    s_k  = k;
                    kind = {ofst_ld, clr, tick_ld};
                end
            end
            if (host_ack || srv_ack) begin
                a_k = k;
                h   = host_ack;
                s   = srv_ack;
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1; rtc_ns = 32'd500_000_000;
        host_req = 0; host_op = 2'b11; host_sc = '0; host_ns = '0; host_tick = '0;
        srv_req = 0;  srv_op = 2'b11;  srv_sc = '0;  srv_ns = '0;  srv_tick = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tick_inc", tick_inc, 32'h1999_999a);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sc_ofst", sc_ofst, 0);
        check_eq("rst_defer", defer_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain host offset load, mid-second.
        host_req = 1; host_op = 2'b00; host_sc = 48'h0011_1234_5678; host_ns = 32'h0150_0000;
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        host_req = 0;
        check_eq("t1_strb_k", strb_k, 2);
        check_eq("t1_strb_kind", strb_kind, 3'b100);
        check_eq("t1_ack_k", ack_k, 6);
        check_eq("t1_ack_host", {hack, sack}, 2'b10);
        check_eq("t1_n_strb", n_strb, 1);
        check_eq("t1_sc", sc_ofst, 48'h0011_1234_5678);
        check_eq("t1_ns", ns_ofst, 32'h0150_0000);
        check_eq("t1_defer", defer_cnt, 0);

        // Offset load across the rollover; exits exactly at ns == GUARD_NS.
        @(posedge clk); #1;
        host_req = 1; host_sc = 48'h1; host_ns = 32'h10; rtc_ns = 32'd999_500_000;
        ns_step = 100_000;
        wait_ack(60, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        ns_step = 0; host_req = 0;
        check_eq("t2_strb_k", strb_k, 16);
        check_eq("t2_ack_k", ack_k, 20);
        check_eq("t2_defer", defer_cnt, 14);
        check_eq("t2_ns", ns_ofst, 32'h10);

        // Host clear beats servo offset load despite the round-robin favouring the servo.
        @(posedge clk); #1;
        rtc_ns = 32'd999_990_000;
        host_req = 1; host_op = 2'b01;
        srv_req = 1; srv_op = 2'b00; srv_sc = 48'h0000_0abc_def0; srv_ns = 32'h0000_1234;
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        host_req = 0;
        check_eq("t3_clr_k", strb_k, 2);
        check_eq("t3_clr_kind", strb_kind, 3'b010);
        check_eq("t3_host_ack", {hack, sack, 6'(ack_k)}, {2'b10, 6'd6});
        wait_ack(10, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        check_eq("t3_srv_deferred", {n_strb, ack_k}, {32'd0, -32'sd1});
        check_eq("t3_busy", busy, 1);
        rtc_ns = 32'd500_000_000;
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        srv_req = 0;
        check_eq("t3_srv_strb_k", strb_k, 1);
        check_eq("t3_srv_kind", strb_kind, 3'b100);
        check_eq("t3_srv_ack", {hack, sack, 6'(ack_k)}, {2'b01, 6'd5});
        check_eq("t3_srv_sc", sc_ofst, 48'h0000_0abc_def0);
        check_eq("t3_defer", defer_cnt, 22);

        // Continuous tick_inc loads from both sides alternate.
        @(posedge clk); #1;
        host_req = 1; host_op = 2'b10; host_tick = 32'h1999_999a;
        srv_req = 1;  srv_op = 2'b10;  srv_tick = 32'h1999_999b;
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        check_eq("t4_a", {hack, sack, 6'(strb_k), 6'(ack_k)}, {2'b10, 6'd2, 6'd6});
        check_eq("t4_a_tick", tick_inc, 32'h1999_999a);
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        check_eq("t4_b", {hack, sack, 6'(strb_k), 6'(ack_k)}, {2'b01, 6'd3, 6'd7});
        check_eq("t4_b_tick", tick_inc, 32'h1999_999b);
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        host_req = 0; srv_req = 0;
        check_eq("t4_c", {hack, sack, 3'(strb_kind)}, {2'b10, 3'b001});
        check_eq("t4_c_tick", tick_inc, 32'h1999_999a);

        // Reset lands during SETTLE of a servo offset load.
        repeat (2) @(posedge clk);
        #1;
        srv_req = 1; srv_op = 2'b00; srv_sc = 48'h0000_0000_0abc; srv_ns = 32'h123;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t5_pre_rst_sc", sc_ofst, 48'h0000_0000_0abc);
        rst = 1; srv_req = 0;
        @(posedge clk); #1;
        rst = 0;
        check_eq("t5_rst_outs", {ofst_ld, clr, tick_ld, busy, srv_ack, host_ack}, 6'b0);
        check_eq("t5_rst_data", {sc_ofst, ns_ofst, defer_cnt}, 96'h0);
        check_eq("t5_rst_tick", tick_inc, 32'h1999_999a);
        acks_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (srv_ack || host_ack) acks_seen++;
        end
        check_eq("t5_no_ack", acks_seen, 0);
        srv_req = 1;
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        srv_req = 0;
        check_eq("t5_reissue", {hack, sack, 6'(strb_k), 6'(ack_k)}, {2'b01, 6'd2, 6'd6});
        check_eq("t5_reissue_ns", ns_ofst, 32'h123);

        // Servo nop: ack without strobe.
        @(posedge clk); #1;
        srv_req = 1; srv_op = 2'b11;
        wait_ack(20, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        srv_req = 0;
        check_eq("t6_nop", {hack, sack, 6'(ack_k), 6'(n_strb)}, {2'b01, 6'd1, 6'd0});
        check_eq("t6_busy_ack", busy, 1);
        @(posedge clk); #1;
        check_eq("t6_busy_after", {busy, srv_ack}, 2'b00);

        // Illegal ns counts as inside; 998_999_999 is just outside the upper edge.
        @(posedge clk); #1;
        rtc_ns = 32'hFFFF_FFFF;
        host_req = 1; host_op = 2'b00; host_sc = 48'h77; host_ns = 32'h88;
        wait_ack(5, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        check_eq("t7_blocked", {n_strb, ack_k}, {32'd0, -32'sd1});
        rtc_ns = 32'd998_999_999;
        wait_ack(40, strb_k, ack_k, n_strb, strb_kind, hack, sack);
        host_req = 0;
        check_eq("t7_done", {hack, sack, 6'(strb_k), 6'(ack_k)}, {2'b10, 6'd1, 6'd5});
        check_eq("t7_defer", defer_cnt, 4);

        repeat (2) @(posedge clk);
        #1;
        check_eq("exclusivity", excl_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
